// File: rtl/btn_debounce_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce_pkg : badge button constants and sizing helper         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package btn_debounce_pkg;

  localparam int BADGE_N_BTN        = 8;
  localparam int BTN_RELOAD_IDX     = 4;

  // 8 MHz badge clock: ~0.5 ms tick, ~4 ms settle, ~2 s long press
  localparam int BADGE_TICK_DIV     = 4096;
  localparam int BADGE_SETTLE_TICKS = 8;
  localparam int BADGE_LONG_TICKS   = 4096;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce_ch : one debounced channel with press/release/long     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int SETTLE_TICKS = BADGE_SETTLE_TICKS,
  parameter int LONG_TICKS   = BADGE_LONG_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic smp_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW = cnt_width(SETTLE_TICKS);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;

    // Agreement on any cycle, not just ticks, restarts settling
    if (smp_i == state_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        state_d = smp_i;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (!state_q) begin
      hold_d = '0;
    end else if (tick_i && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
    end

    press_d   = state_d & ~state_q;
    release_d = ~state_d & state_q;
    long_d    = state_q & tick_i & (hold_q == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce : synchronise, tick-prescale and debounce N buttons    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN        = BADGE_N_BTN,
  parameter int TICK_DIV     = BADGE_TICK_DIV,
  parameter int SETTLE_TICKS = BADGE_SETTLE_TICKS,
  parameter int LONG_TICKS   = BADGE_LONG_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             w_tick;
  logic [N_BTN-1:0] w_smp;

  // Sync flops idle high so a reset reads as "all released"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  assign w_smp  = ~sync2_q;
  assign w_tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (w_tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .SETTLE_TICKS (SETTLE_TICKS),
      .LONG_TICKS   (LONG_TICKS)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick_i    (w_tick),
      .smp_i     (w_smp[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i]),
      .long_o    (btn_long[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_btn_debounce : directed vectors and corner sequences             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_btn_debounce;

  localparam int NB = 8;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 10;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] btn     = 8'hFF;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int press_cnt [NB] = '{default: 0};
  int rel_cnt   [NB] = '{default: 0};
  int long_cnt  [NB] = '{default: 0};
  int clash = 0;

  btn_debounce #(
    .N_BTN        (NB),
    .TICK_DIV     (TD),
    .SETTLE_TICKS (ST),
    .LONG_TICKS   (LT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NB; i++) begin
        if (btn_press[i])   press_cnt[i]++;
        if (btn_release[i]) rel_cnt[i]++;
        if (btn_long[i])    long_cnt[i]++;
      end
      if ((btn_press & btn_release) != '0) clash = 1;
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [NB-1:0] get(input int sel);
    case (sel)
      0:       return btn_level;
      1:       return btn_press;
      2:       return btn_release;
      default: return btn_long;
    endcase
  endfunction

  task automatic wait_bit(input int sel, input int b, input int budget, output int at);
    logic [NB-1:0] v;
    at = -1;
    for (int k = 0; k < budget; k++) begin
      v = get(sel);
      if (v[b]) begin
        at = cyc;
        return;
      end
      step(1);
    end
  endtask

  // Input driven in cycle d is seen as smp in d+2; acceptance lands on
  // the ST-th tick and becomes visible the cycle after it.
  function automatic int exp_accept(input int d);
    int t;
    t = d + 2;
    while ((t % TD) != (TD - 1)) t++;
    return t + TD * (ST - 1) + 1;
  endfunction

  typedef struct {
    logic [NB-1:0] btn;
    int            steps;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] lng;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int            at, at_p, at_l, d, last_hi, lvl2_seen;
    logic [NB-1:0] v;

    tbl[0] = '{8'hFE, 11, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{8'hFE,  1, 8'h01, 8'h01, 8'h00, 8'h00};
    tbl[2] = '{8'hFE,  1, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'hFE, 38, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{8'hFE,  1, 8'h01, 8'h00, 8'h00, 8'h01};
    tbl[5] = '{8'hFE,  1, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{8'hFF, 10, 8'h01, 8'h00, 8'h00, 8'h00};
    tbl[7] = '{8'hFF,  1, 8'h00, 8'h00, 8'h01, 8'h00};
    tbl[8] = '{8'hFF,  1, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset with all buttons released
    step(3);
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_release", btn_release, 0);
    chk("rst_long", btn_long, 0);
    reset_n = 1'b1;
    cyc = 0;
    chk("post_rst_level", btn_level, 0);
    chk("post_rst_press", btn_press, 0);
    chk("post_rst_release", btn_release, 0);
    chk("post_rst_long", btn_long, 0);

    // Clean press, long press, release on channel 0
    for (int r = 0; r < 9; r++) begin
      btn = tbl[r].btn;
      step(tbl[r].steps);
      chk($sformatf("vec%0d_level", r), btn_level, tbl[r].lvl);
      chk($sformatf("vec%0d_press", r), btn_press, tbl[r].prs);
      chk($sformatf("vec%0d_release", r), btn_release, tbl[r].rel);
      chk($sformatf("vec%0d_long", r), btn_long, tbl[r].lng);
    end

    // Bounce on channel 2: 5 low / 1 high for 40 cycles
    last_hi = 0;
    lvl2_seen = 0;
    for (int i = 0; i < 40; i++) begin
      btn[2] = ((i % 6) == 5);
      if ((i % 6) == 5) last_hi = cyc;
      step(1);
      if (btn_level[2]) lvl2_seen = 1;
    end
    chk("bounce_level", lvl2_seen, 0);
    chk("bounce_press_cnt", press_cnt[2], 0);
    wait_bit(0, 2, 40, at);
    chk("bounce_accept_cyc", at, exp_accept(last_hi + 1));
    v = btn_press;
    chk("bounce_press_pulse", v[2], 1);

    // Simultaneous press on channels 1 and 7
    d = cyc;
    btn[1] = 1'b0;
    btn[7] = 1'b0;
    wait_bit(1, 1, 40, at);
    v = btn_press;
    chk("simul_press_vec", v & 8'h82, 8'h82);
    chk("simul_cyc", at, exp_accept(d));

    // Long press and release on channel 4
    d = cyc;
    btn[4] = 1'b0;
    wait_bit(1, 4, 40, at_p);
    chk("long_press_cyc", at_p, exp_accept(d));
    wait_bit(3, 4, 60, at_l);
    chk("long_delay", at_l - at_p, TD * LT);
    step(30);
    chk("long_once_held", long_cnt[4], 1);
    d = cyc;
    btn[4] = 1'b1;
    wait_bit(2, 4, 40, at);
    chk("long_release_cyc", at, exp_accept(d));
    step(20);
    chk("long_none_on_release", long_cnt[4], 1);
    chk("long_release_cnt", rel_cnt[4], 1);

    // Reset while channel 3 is pressed
    btn[3] = 1'b0;
    wait_bit(0, 3, 40, at);
    chk("mid_level_before", at >= 0, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_level", btn_level, 0);
    chk("mid_rst_press", btn_press, 0);
    chk("mid_rst_release", btn_release, 0);
    chk("mid_rst_long", btn_long, 0);
    step(2);
    reset_n = 1'b1;
    cyc = 0;
    wait_bit(1, 3, 40, at);
    chk("mid_repress_cyc", at, exp_accept(0));
    step(2);
    chk("mid_no_release", rel_cnt[3], 0);
    chk("no_press_release_clash", clash, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Conditions the badge's raw active-low push buttons before any project logic consumes them. It synchronises each button, debounces it against a shared tick prescaler, and produces a clean pressed level plus one-cycle press, release and long-press pulses. It sits directly upstream of the LED and reload logic in badge projects, which consume the pressed level and pulses instead of raw btn bits.

Parameters:
N_BTN, 8, number of button channels.
TICK_DIV, 4096, clk cycles per debounce tick (minimum 2).
SETTLE_TICKS, 8, consecutive ticks of differing input needed to accept a change (minimum 1).
LONG_TICKS, 4096, ticks a button must be held before btn_long fires (must be greater than SETTLE_TICKS).

Ports:
clk  in  1  system clock; sole clock domain.
reset_n  in  1  asynchronous assert, active-low reset.
btn  in  N_BTN  raw buttons; active-low (0 = pressed); asynchronous to clk.
btn_level  out  N_BTN  debounced state; 1 = pressed.
btn_press  out  N_BTN  one-cycle pulse when btn_level rises.
btn_release  out  N_BTN  one-cycle pulse when btn_level falls.
btn_long  out  N_BTN  one-cycle pulse when a press has been held for LONG_TICKS ticks.

Behaviour:
- Reset: one clock, clk. reset_n asynchronous, active-low. All registers clear asynchronously. Synchroniser flops reset to 1 (released). Prescaler resets to 0. All outputs are 0 during reset.
- Synchroniser: 2-FF per bit, then inverted, giving smp[i] (1 = pressed). Two-cycle latency from pin to smp.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 for exactly one cycle when count == TICK_DIV-1. A single prescaler is shared by all channels.
- Per channel, state is the register behind btn_level, plus cnt (settle counter) and hold (long-press counter).
  - Any cycle with smp == state: cnt <= 0. This applies on every cycle, not only on ticks, so a glitch between ticks restarts settling.
  - Tick with smp != state and cnt < SETTLE_TICKS-1: cnt <= cnt+1.
  - Tick with smp != state and cnt == SETTLE_TICKS-1: state <= smp; cnt <= 0.
  - Acceptance therefore needs SETTLE_TICKS consecutive ticks of disagreement.
- Pulses are registered:
  - btn_press = state rose on the previous edge.
  - btn_release = state fell on the previous edge.
  - Each pulse is exactly 1 cycle. btn_press and btn_release never assert together on one channel.
- Long press:
  - hold clears while state == 0.
  - While state == 1, hold increments on each tick and saturates at LONG_TICKS.
  - btn_long pulses for one cycle on the tick where hold goes LONG_TICKS-1 -> LONG_TICKS. It fires at most once per press.
- Channels are fully independent. Simultaneous events on different channels all produce their own pulses in the same cycle.
- Button held through reset: after reset_n rises, state starts at 0. The hold is accepted as a new press after SETTLE_TICKS ticks and emits btn_press (power-on holds are reported, never suppressed).
- reset_n asserted mid-press: outputs drop to 0 immediately. No btn_release is emitted.
- Widths:
  - cnt is $clog2(SETTLE_TICKS) bits, minimum 1.
  - hold is $clog2(LONG_TICKS+1) bits.
  - The prescaler is $clog2(TICK_DIV) bits.
  - No counter wraps except the prescaler.

Decomposition:
- Shared badge package holds: BADGE_N_BTN = 8; BTN_RELOAD_IDX = 4 (the button that triggers FPGA reload); default TICK_DIV, SETTLE_TICKS and LONG_TICKS for the 8 MHz badge clock (about 0.5 ms tick, 4 ms settle, 2 s long press).
- One sub-module is natural: btn_debounce_ch, a single channel containing cnt, hold, state and pulse registers.
  - It takes tick and smp as inputs.
  - The top level holds the synchroniser and prescaler and instantiates N_BTN channels in a generate loop.

Test Plan:
All scenarios use TICK_DIV=4, SETTLE_TICKS=3, LONG_TICKS=10, N_BTN=8.
1. Reset: hold reset_n=0 with btn=8'hFF, release -> all outputs 0; prescaler tick first seen 4 cycles after reset release.
2. Clean press: drive btn[0]=0 and hold -> btn_level[0]=1 after 2 sync cycles + 3 ticks (at most 14 cycles); btn_press[0] high exactly 1 cycle; other bits stay 0.
3. Bounce: toggle btn[2] low for 5 cycles, high for 1, low for 5, repeated for 40 cycles -> no btn_press[2] and btn_level[2] stays 0; then hold low -> press accepted 3 ticks after the last bounce.
4. Long press: hold btn[4]=0 -> btn_long[4] pulses once, 10 ticks (40 cycles) after btn_press[4], and not again while held; release -> btn_release[4] after 3 ticks; btn_long never fires on release.
5. Simultaneous: press btn[1] and btn[7] in the same cycle -> btn_press[1] and btn_press[7] assert in the same cycle.
6. Reset mid-press: with btn_level[3]=1, pulse reset_n low for 2 cycles with btn[3] still 0 -> outputs 0 immediately, no btn_release[3], then btn_press[3] again 3 ticks after reset release.
